// File: rtl/otter_operand_fetch.sv
// otter_operand_fetch: reads both source operands with writeback forwarding, stalls on scoreboard hazards,
// and holds them in a one-entry output register for execute.
module otter_operand_fetch #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic             in_use_rs1,
    input  logic             in_use_rs2,
    input  logic [4:0]       in_rd,
    input  logic             in_rd_wen,
    input  logic [XLEN-1:0]  in_pc,
    output logic [4:0]       rf_read1,
    output logic [4:0]       rf_read2,
    input  logic [XLEN-1:0]  rf_data1,
    input  logic [XLEN-1:0]  rf_data2,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_op1,
    output logic [XLEN-1:0]  out_op2,
    output logic [4:0]       out_rd,
    output logic             out_rd_wen,
    output logic [XLEN-1:0]  out_pc,
    output logic [31:0]      busy_mask,
    output logic [CNT_W-1:0] stall_cnt
);
    logic [31:0]     busy, set_m, clr_m;
    logic            hit1, hit2, hitd, hazard, accept;
    logic [XLEN-1:0] op1, op2;

    assign rf_read1  = in_rs1;
    assign rf_read2  = in_rs2;
    assign busy_mask = busy;

    // A writeback landing this cycle retires its register, so it neither stalls nor reads stale RF data
    always_comb begin
        hit1   = wb_valid && wb_rd == in_rs1 && in_rs1 != 5'd0;
        hit2   = wb_valid && wb_rd == in_rs2 && in_rs2 != 5'd0;
        hitd   = wb_valid && wb_rd == in_rd && in_rd != 5'd0;
        hazard = (in_use_rs1 && in_rs1 != 5'd0 && busy[in_rs1] && !hit1) ||
                 (in_use_rs2 && in_rs2 != 5'd0 && busy[in_rs2] && !hit2) ||
                 (in_rd_wen && in_rd != 5'd0 && busy[in_rd] && !hitd);
        in_ready = (!out_valid || out_ready) && !hazard;
        accept   = in_valid && in_ready;
        op1      = (in_rs1 == 5'd0) ? '0 : hit1 ? wb_data : rf_data1;
        op2      = (in_rs2 == 5'd0) ? '0 : hit2 ? wb_data : rf_data2;
        clr_m    = (wb_valid && wb_rd != 5'd0) ? 32'd1 << wb_rd : 32'd0;
        set_m    = (accept && in_rd_wen && in_rd != 5'd0) ? 32'd1 << in_rd : 32'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy       <= '0;
            out_valid  <= 1'b0;
            out_op1    <= '0;
            out_op2    <= '0;
            out_rd     <= '0;
            out_rd_wen <= 1'b0;
            out_pc     <= '0;
            stall_cnt  <= '0;
        end else begin
            busy <= (busy & ~clr_m) | set_m;
            if (in_valid && !in_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (accept) begin
                out_valid  <= 1'b1;
                out_op1    <= op1;
                out_op2    <= op2;
                out_rd     <= in_rd;
                out_rd_wen <= in_rd_wen;
                out_pc     <= in_pc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_otter_operand_fetch.sv
// tb_otter_operand_fetch: directed plan plus randomized traffic against a pending-register reference model.
module tb_otter_operand_fetch;
    logic        clock = 1'b0, reset;
    logic        in_valid, in_ready, in_use_rs1, in_use_rs2, in_rd_wen;
    logic [4:0]  in_rs1, in_rs2, in_rd, rf_read1, rf_read2, wb_rd, out_rd;
    logic [31:0] in_pc, rf_data1, rf_data2, wb_data, out_op1, out_op2, out_pc, busy_mask;
    logic        wb_valid, out_valid, out_ready, out_rd_wen;
    logic [15:0] stall_cnt;

    logic [31:0] rf [32];
    bit          pend [32];
    logic        mv, mwen;
    logic [31:0] mop1, mop2, mpc;
    logic [4:0]  mrd;
    logic [15:0] mst;
    int          checks = 0, failures = 0;

    always #5 clock = ~clock;
    assign rf_data1 = rf[rf_read1];
    assign rf_data2 = rf[rf_read2];

    otter_operand_fetch dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_pc(in_pc),
        .rf_read1(rf_read1), .rf_read2(rf_read2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_pc(out_pc),
        .busy_mask(busy_mask), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit still_busy(input logic [4:0] r);
        return r != 5'd0 && pend[r] && !(wb_valid && wb_rd == r);
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_valid && wb_rd == r) return wb_data;
        return rf[r];
    endfunction

    function automatic logic [31:0] pend_mask();
        logic [31:0] m = 32'd0;
        for (int i = 0; i < 32; i++) m[i] = pend[i];
        return m;
    endfunction

    // One clock: check combinational outputs, advance the model, then check registered outputs
    task automatic step();
        logic rdy, acc;
        logic [31:0] n1, n2;
        rdy = (!mv || out_ready) && !((in_use_rs1 && still_busy(in_rs1)) ||
              (in_use_rs2 && still_busy(in_rs2)) || (in_rd_wen && still_busy(in_rd)));
        acc = in_valid && rdy;
        n1 = operand(in_rs1);
        n2 = operand(in_rs2);
        #1;
        if (!reset) begin
            chk("in_ready", in_ready, rdy);
            chk("rf_read1", rf_read1, in_rs1);
            chk("rf_read2", rf_read2, in_rs2);
        end
        @(posedge clock);
        #1;
        if (reset) begin
            mv = 0; mop1 = 0; mop2 = 0; mrd = 0; mwen = 0; mpc = 0; mst = 0;
            for (int i = 0; i < 32; i++) pend[i] = 0;
        end else begin
            if (in_valid && !rdy && mst != 16'hFFFF) mst++;
            if (wb_valid && wb_rd != 5'd0) pend[wb_rd] = 0;
            if (acc && in_rd_wen && in_rd != 5'd0) pend[in_rd] = 1;
            if (acc) begin
                mv = 1; mop1 = n1; mop2 = n2; mrd = in_rd; mwen = in_rd_wen; mpc = in_pc;
            end else if (out_ready) mv = 0;
        end
        if (wb_valid && wb_rd != 5'd0) rf[wb_rd] = wb_data;
        chk("out_valid", out_valid, mv);
        chk("out_op1", out_op1, mop1);
        chk("out_op2", out_op2, mop2);
        chk("out_rd", out_rd, mrd);
        chk("out_rd_wen", out_rd_wen, mwen);
        chk("out_pc", out_pc, mpc);
        chk("busy_mask", busy_mask, pend_mask());
        chk("stall_cnt", stall_cnt, mst);
    endtask

    task automatic instr(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                         input logic u2, input logic [4:0] d, input logic dw, input logic [31:0] pc);
        in_valid = v; in_rs1 = r1; in_rs2 = r2; in_use_rs1 = u1; in_use_rs2 = u2;
        in_rd = d; in_rd_wen = dw; in_pc = pc;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin rf[i] = $urandom; pend[i] = 0; end
        rf[0] = 32'hBAD0_0000;
        rf[5] = 32'h11;
        rf[6] = 32'h22;
        mv = 0; mop1 = 0; mop2 = 0; mrd = 0; mwen = 0; mpc = 0; mst = 0;
        // Reset held two cycles with a writeback that must be ignored
        reset = 1; out_ready = 1; wb_valid = 1; wb_rd = 3; wb_data = 32'h33;
        instr(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        reset = 0; wb_valid = 0;
        step();
        chk("t1_ready", in_ready, 1'b1);
        chk("t1_busy", busy_mask, 32'd0);
        // Independent issue
        instr(1, 5, 6, 1, 1, 7, 1, 32'h100);
        step();
        chk("t2_op1", out_op1, 32'h11);
        chk("t2_op2", out_op2, 32'h22);
        chk("t2_pc", out_pc, 32'h100);
        chk("t2_busy", busy_mask, 32'h80);
        // RAW on x7 for three cycles, then released by the forwarded writeback
        instr(1, 7, 0, 1, 0, 8, 0, 32'h104);
        repeat (3) step();
        chk("t3_stall", stall_cnt, 16'd3);
        wb_valid = 1; wb_rd = 7; wb_data = 32'hDEAD;
        step();
        chk("t3_op1", out_op1, 32'hDEAD);
        chk("t3_busy7", busy_mask[7], 1'b0);
        // x0 sources and destination with a writeback to x0
        wb_rd = 0; wb_data = 32'h55;
        instr(1, 0, 0, 1, 1, 0, 1, 32'h108);
        step();
        wb_valid = 0;
        chk("t4_op1", out_op1, 32'd0);
        chk("t4_op2", out_op2, 32'd0);
        chk("t4_busy", busy_mask, 32'd0);
        // Backpressure holds the output, then a back-to-back accept
        instr(1, 5, 6, 1, 1, 0, 0, 32'h200);
        step();
        out_ready = 0;
        instr(1, 6, 5, 1, 1, 0, 0, 32'h300);
        repeat (5) begin
            step();
            chk("t5_hold_pc", out_pc, 32'h200);
        end
        out_ready = 1;
        step();
        chk("t5_b2b_valid", out_valid, 1'b1);
        chk("t5_b2b_pc", out_pc, 32'h300);
        // Same-cycle set and clear of x9: the new producer keeps it busy
        instr(1, 0, 0, 0, 0, 9, 1, 32'h400);
        step();
        chk("t6_busy9_set", busy_mask[9], 1'b1);
        wb_valid = 1; wb_rd = 9; wb_data = 32'h99;
        instr(1, 0, 0, 0, 0, 9, 1, 32'h500);
        step();
        chk("t6_pc", out_pc, 32'h500);
        chk("t6_busy9", busy_mask[9], 1'b1);
        // Randomized traffic over a small register window to provoke hazards and forwarding
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 79) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            wb_valid = ($urandom_range(0, 9) < 4);
            wb_rd = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            instr(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/otter_operand_fetch.md
Name: otter_operand_fetch

Overview:
- Read-side companion to the OTTER register file: consumes decoded instructions, drives the register file's two read addresses, and captures both source operands into a one-entry output register for execute.
- A 32-bit busy scoreboard tracks in-flight destination registers and stalls RAW/WAW hazards until the matching writeback arrives.
- Writeback data is forwarded on the cycle it is written, covering the register file's write-on-edge timing.
- Sits between decode and execute in the pipelined/multicycle OTTER.

Parameters:
XLEN, 32, operand/data width
CNT_W, 16, width of saturating stall counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  block accepts instruction this cycle
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_use_rs1  in  1  instruction reads rs1
in_use_rs2  in  1  instruction reads rs2
in_rd  in  5  destination register
in_rd_wen  in  1  instruction writes rd
in_pc  in  XLEN  instruction address, passed through
rf_read1  out  5  register file read address 1 (= in_rs1, combinational)
rf_read2  out  5  register file read address 2 (= in_rs2, combinational)
rf_data1  in  XLEN  register file read data 1 (combinational)
rf_data2  in  XLEN  register file read data 2 (combinational)
wb_valid  in  1  writeback this cycle (same signals drive the register file write port)
wb_rd  in  5  writeback register
wb_data  in  XLEN  writeback data
out_valid  out  1  operands valid to execute
out_ready  in  1  execute accepts operands
out_op1  out  XLEN  operand 1
out_op2  out  XLEN  operand 2
out_rd  out  5  destination register
out_rd_wen  out  1  destination write enable
out_pc  out  XLEN  passed-through PC
busy_mask  out  32  scoreboard state; bit 0 is always 0
stall_cnt  out  CNT_W  cycles with in_valid=1 and in_ready=0 (saturating)

Behaviour:
- Reset (synchronous): busy_mask=0, out_valid=0, all out_* fields=0, stall_cnt=0. A writeback in the reset cycle is ignored. An accepted-but-unconsumed output is discarded.
- Define wbhit(r) = wb_valid && wb_rd==r && r!=0.
- Define busy_eff(r) = busy[r] && !wbhit(r).
- Hazard condition:
  - (in_use_rs1 && in_rs1!=0 && busy_eff(in_rs1)), or
  - (in_use_rs2 && in_rs2!=0 && busy_eff(in_rs2)), or
  - (in_rd_wen && in_rd!=0 && busy_eff(in_rd)) — WAW case.
- in_ready = (!out_valid || out_ready) && !hazard. It is combinational and does not depend on in_valid.
- Accept = in_valid && in_ready. On accept, on the next edge:
  - out_valid=1.
  - op1 = 0 if in_rs1==0; else wb_data if wbhit(in_rs1); else rf_data1. op2 is formed the same way from in_rs2.
  - Operands for unused sources are still captured by the same rule (don't-care downstream).
  - out_rd, out_rd_wen and out_pc are registered.
  - If in_rd_wen && in_rd!=0, busy[in_rd] is set.
- Latency: one cycle from accept to out_valid.
- out_valid && out_ready without a new accept: out_valid clears next edge.
- Accept in the same cycle as out_ready: back-to-back, and out_valid stays 1.
- While out_valid && !out_ready, all out_* fields hold stable.
- Scoreboard:
  - wb_valid with wb_rd!=0 clears busy[wb_rd].
  - A simultaneous set from accept and clear from writeback to the same register: set wins (the new producer owns it).
  - A writeback to a non-busy register changes nothing in the scoreboard, but is still forwarded.
  - wb_rd==0 is ignored.
- stall_cnt increments on each cycle with in_valid && !in_ready, whether the cause is backpressure or hazard. It saturates at all-ones.
- Output and scoreboard state are updated only on clock edges. in_ready, rf_read1 and rf_read2 are combinational.

Test Plan:
1. Reset: hold reset 2 cycles with wb_valid=1, wb_rd=3 -> out_valid=0, busy_mask=0, stall_cnt=0, in_ready=1.
2. Independent issue: RF x5=0x11, x6=0x22; in rs1=5, rs2=6, rd=7, rd_wen=1, pc=0x100 -> next cycle out_op1=0x11, out_op2=0x22, out_rd=7, out_pc=0x100, busy_mask=0x00000080.
3. RAW stall and release:
   - Stimulus: x7 busy; instruction with rs1=7 held 3 cycles -> in_ready=0, stall_cnt=3.
   - Then wb_valid=1, wb_rd=7, wb_data=0xDEAD -> accepted that cycle, out_op1=0xDEAD, busy[7]=0.
4. x0 handling: rs1=0, rs2=0, rd=0, rd_wen=1 with wb to x0 -> out_op1=0, out_op2=0, no stall, busy_mask unchanged.
5. Backpressure: out_valid=1, out_ready=0 for 5 cycles -> in_ready=0 and out_* stable; then out_ready=1 with a new in_valid -> accepted back-to-back, out_valid stays 1.
6. Set beats clear: x9 busy; wb_rd=9 in the same cycle as an accepted instruction with rd=9 -> no WAW stall, busy[9] remains 1.
